m_ctrl_unit: RTL and testbench
==============================

Name: m_ctrl_unit

Overview:
- Multi-cycle MIPS control FSM that drives the `M_datapath` control inputs.
- Consumes the `Inst`, `zero` and `MIO_ready` outputs of `M_datapath`.
- Produces every datapath control signal, plus memory strobes toward the MIO bus.
- Outputs are Moore-decoded from a registered state; instruction fields are read from `Inst` (the IR) while the FSM is in ID.

Parameters:
- `STATE_W`, 4, width of `state_out`.

Ports:
- `clk`, in, 1, system clock; all state updates on the rising edge.
- `reset`, in, 1, synchronous, active-high.
- `Inst`, in, 32, current IR contents from the datapath.
- `zero`, in, 1, ALU zero flag.
- `MIO_ready`, in, 1, memory/IO ready for the current access.
- `IorD`, out, 1, address select: 0 = PC, 1 = ALUOut.
- `IRWrite`, out, 1, load IR.
- `MemRead`, out, 1, memory read strobe.
- `MemWrite`, out, 1, memory write strobe.
- `CPU_MIO`, out, 1, bus request; equals `MemRead` | `MemWrite`.
- `RegDst`, out, 2, write register select: 00 = rt, 01 = rd, 10 = $31.
- `RegWrite`, out, 1, register file write enable.
- `MemtoReg`, out, 2, write-back source: 00 = ALUOut, 01 = MDR, 10 = {imm,16'h0}, 11 = PC.
- `ALUSrcA`, out, 1, ALU A select: 0 = PC, 1 = reg A.
- `ALUSrcB`, out, 2, ALU B select: 00 = reg B, 01 = 4, 10 = sext(imm), 11 = sext(imm)<<2.
- `PCSource`, out, 2, next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = reg A.
- `PCWrite`, out, 1, unconditional PC load.
- `PCWriteCond`, out, 1, conditional PC load.
- `Branch`, out, 1, branch sense: 1 = beq (taken on `zero`), 0 = bne (taken on !`zero`).
- `ALU_operation`, out, 3, ALU opcode: AND 000, OR 001, ADD 010, XOR 011, NOR 100, SRL 101, SUB 110, SLT 111.
- `state_out`, out, 4, current state, for debug and the bench.

Behaviour:

Reset:
- While `reset` = 1, all outputs are 0.
- On the first edge with `reset` = 1, the state becomes IF (0). `reset` mid-instruction aborts the instruction at that edge.

State encodings:
- IF 0, ID 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXE 6, R_WB 7, BRANCH 8, JUMP 9, I_EXE 10, I_WB 11, LUI 12, JAL 13, JR 14.
- Encoding 15 is illegal; the FSM goes to IF on the next edge with all outputs 0.

Per-state outputs (any signal not listed is 0):
- IF: `MemRead`, `CPU_MIO`, `IorD` = 0, `ALUSrcA` = 0, `ALUSrcB` = 01, ADD, `PCSource` = 00. `IRWrite` = `PCWrite` = `MIO_ready`. Stays in IF while `MIO_ready` = 0; goes to ID when it is 1.
- ID: `ALUSrcA` = 0, `ALUSrcB` = 11, ADD (branch target into ALUOut). Dispatch on `Inst[31:26]`:
  - 000000 with funct 001000 (jr) -> JR; any other supported funct -> R_EXE.
  - 100011 lw, 101011 sw -> MEM_ADDR.
  - 000100 beq, 000101 bne -> BRANCH.
  - 001000 addi, 001100 andi, 001101 ori, 001110 xori, 001010 slti -> I_EXE.
  - 001111 lui -> LUI.
  - 000010 j -> JUMP.
  - 000011 jal -> JAL.
  - Unsupported opcode or funct -> IF (executes as a NOP; PC has already advanced).
- MEM_ADDR: `ALUSrcA` = 1, `ALUSrcB` = 10, ADD. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `MemRead`, `IorD` = 1. Holds while `MIO_ready` = 0, then goes to MEM_WB.
- MEM_WB: `RegWrite`, `RegDst` = 00, `MemtoReg` = 01. Goes to IF.
- MEM_WR: `MemWrite`, `IorD` = 1. Holds while `MIO_ready` = 0, then goes to IF.
- R_EXE: `ALUSrcA` = 1, `ALUSrcB` = 00. `ALU_operation` by funct: add 100000 ADD, sub 100010 SUB, and 100100 AND, or 100101 OR, xor 100110 XOR, nor 100111 NOR, slt 101010 SLT, srl 000010 SRL. Goes to R_WB.
- R_WB: `RegWrite`, `RegDst` = 01, `MemtoReg` = 00. Goes to IF.
- BRANCH: `ALUSrcA` = 1, `ALUSrcB` = 00, SUB, `PCWriteCond`, `PCSource` = 01, `Branch` = ~`Inst[26]`. Goes to IF.
- I_EXE: `ALUSrcA` = 1, `ALUSrcB` = 10. Op: addi ADD, andi AND, ori OR, xori XOR, slti SLT. Goes to I_WB.
- I_WB: `RegWrite`, `RegDst` = 00, `MemtoReg` = 00. Goes to IF.
- LUI: `RegWrite`, `RegDst` = 00, `MemtoReg` = 10. Goes to IF.
- JUMP: `PCWrite`, `PCSource` = 10. Goes to IF.
- JAL: `PCWrite`, `PCSource` = 10, `RegWrite`, `RegDst` = 10, `MemtoReg` = 11. Goes to IF. PC is written at the same edge, so $31 gets PC+4.
- JR: `PCWrite`, `PCSource` = 11. Goes to IF.

Cycle counts (with `MIO_ready` held 1):
- j, jal, jr, lui, beq, bne: 3.
- R-type, I-type ALU, sw: 4.
- lw: 5.
- Each `MIO_ready` = 0 cycle in IF, MEM_RD or MEM_WR adds one cycle. No other state ever stalls.

Test Plan:
- Reset held 2 cycles, `MIO_ready` = 1 -> all outputs 0 during reset; `state_out` = 0 after release. In IF: `IRWrite` = 1, `PCWrite` = 1, `ALUSrcB` = 01, `ALU_operation` = 010.
- `Inst` = 32'h00221820 (add $3,$1,$2) -> `state_out` 0,1,6,7,0. In R_EXE `ALU_operation` = 010. In R_WB `RegWrite` = 1, `RegDst` = 01.
- `Inst` = 32'h8C230004 (lw), `MIO_ready` low for 2 cycles in MEM_RD -> states 0,1,2,3,3,3,4,0. `IorD` = 1 throughout MEM_RD. `MemtoReg` = 01 in MEM_WB.
- `Inst` = 32'h10220003 (beq) -> BRANCH shows `PCWriteCond` = 1, `Branch` = 1, `ALU_operation` = 110. With 32'h14220003 (bne) -> `Branch` = 0.
- `Inst` = 32'h0C000010 (jal) -> states 0,1,13,0. In JAL: `RegDst` = 10, `MemtoReg` = 11, `PCSource` = 10, `PCWrite` = 1.
- `Inst` = 32'hFC000000 (unsupported) -> states 0,1,0 with no write strobes. `reset` asserted in MEM_ADDR -> state 0 on the next edge.

Source files
------------

// File: rtl/m_ctrl_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// m_ctrl_unit : multi-cycle MIPS control FSM driving the M_datapath controls
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module m_ctrl_unit #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        Inst,
  input  logic               zero,
  input  logic               MIO_ready,
  output logic               IorD,
  output logic               IRWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               CPU_MIO,
  output logic [1:0]         RegDst,
  output logic               RegWrite,
  output logic [1:0]         MemtoReg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               Branch,
  output logic [2:0]         ALU_operation,
  output logic [STATE_W-1:0] state_out
);

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXE    = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXE    = 4'd10,
    S_I_WB     = 4'd11,
    S_LUI      = 4'd12,
    S_JAL      = 4'd13,
    S_JR       = 4'd14
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state_q, state_d;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       r_funct_ok;
  logic [2:0] r_alu_op;
  logic [2:0] i_alu_op;
  logic       unused_ok;

  assign opcode    = Inst[31:26];
  assign funct     = Inst[5:0];
  assign unused_ok = ^{zero, Inst[25:6]};

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  always_comb begin
    r_funct_ok = 1'b1;
    r_alu_op   = ALU_ADD;
    unique case (funct)
      6'b100000: r_alu_op = ALU_ADD;
      6'b100010: r_alu_op = ALU_SUB;
      6'b100100: r_alu_op = ALU_AND;
      6'b100101: r_alu_op = ALU_OR;
      6'b100110: r_alu_op = ALU_XOR;
      6'b100111: r_alu_op = ALU_NOR;
      6'b101010: r_alu_op = ALU_SLT;
      6'b000010: r_alu_op = ALU_SRL;
      default:   r_funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    i_alu_op = ALU_ADD;
    case (opcode)
      6'b001100: i_alu_op = ALU_AND;
      6'b001101: i_alu_op = ALU_OR;
      6'b001110: i_alu_op = ALU_XOR;
      6'b001010: i_alu_op = ALU_SLT;
      default:   i_alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d       = S_IF;
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    RegDst        = 2'b00;
    RegWrite      = 1'b0;
    MemtoReg      = 2'b00;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    PCSource      = 2'b00;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    Branch        = 1'b0;
    ALU_operation = 3'b000;

    case (state_q)
      S_IF: begin
        MemRead       = 1'b1;
        ALUSrcB       = 2'b01;
        ALU_operation = ALU_ADD;
        IRWrite       = MIO_ready;
        PCWrite       = MIO_ready;
        state_d       = MIO_ready ? S_ID : S_IF;
      end
      S_ID: begin
        // Branch target is computed speculatively into ALUOut here
        ALUSrcB       = 2'b11;
        ALU_operation = ALU_ADD;
        case (opcode)
          6'b000000: begin
            if (funct == 6'b001000) state_d = S_JR;
            else if (r_funct_ok)    state_d = S_R_EXE;
            else                    state_d = S_IF;
          end
          6'b100011, 6'b101011: state_d = S_MEM_ADDR;
          6'b000100, 6'b000101: state_d = S_BRANCH;
          6'b001000, 6'b001100, 6'b001101,
          6'b001110, 6'b001010: state_d = S_I_EXE;
          6'b001111:            state_d = S_LUI;
          6'b000010:            state_d = S_JUMP;
          6'b000011:            state_d = S_JAL;
          default:              state_d = S_IF;
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA       = 1'b1;
        ALUSrcB       = 2'b10;
        ALU_operation = ALU_ADD;
        state_d       = (opcode == 6'b101011) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = MIO_ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = MIO_ready ? S_IF : S_MEM_WR;
      end
      S_R_EXE: begin
        ALUSrcA       = 1'b1;
        ALU_operation = r_alu_op;
        state_d       = S_R_WB;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 2'b01;
      end
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALU_operation = ALU_SUB;
        PCWriteCond   = 1'b1;
        PCSource      = 2'b01;
        Branch        = ~Inst[26];
      end
      S_I_EXE: begin
        ALUSrcA       = 1'b1;
        ALUSrcB       = 2'b10;
        ALU_operation = i_alu_op;
        state_d       = S_I_WB;
      end
      S_I_WB: begin
        RegWrite = 1'b1;
      end
      S_LUI: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b10;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_JAL: begin
        // PC still holds PC+4 at this edge, so $31 receives the return address
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        RegWrite = 1'b1;
        RegDst   = 2'b10;
        MemtoReg = 2'b11;
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
      end
      default: state_d = S_IF;
    endcase

    if (reset) begin
      IorD          = 1'b0;
      IRWrite       = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      RegDst        = 2'b00;
      RegWrite      = 1'b0;
      MemtoReg      = 2'b00;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      PCSource      = 2'b00;
      PCWrite       = 1'b0;
      PCWriteCond   = 1'b0;
      Branch        = 1'b0;
      ALU_operation = 3'b000;
    end
  end

  assign CPU_MIO   = MemRead | MemWrite;
  assign state_out = reset ? '0 : STATE_W'(state_q);

endmodule
`default_nettype wire

// File: tb/tb_m_ctrl_unit.sv
`default_nettype none
// Bench for m_ctrl_unit: table of instructions walked through the FSM, plus
// hand-written sequences for reset, stalls and per-state strobes.
module tb_m_ctrl_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Inst;
  logic        zero;
  logic        MIO_ready;
  logic        IorD, IRWrite, MemRead, MemWrite, CPU_MIO;
  logic [1:0]  RegDst;
  logic        RegWrite;
  logic [1:0]  MemtoReg;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB, PCSource;
  logic        PCWrite, PCWriteCond, Branch;
  logic [2:0]  ALU_operation;
  logic [3:0]  state_out;

  int total = 0;
  int bad   = 0;

  m_ctrl_unit #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Inst(Inst), .zero(zero), .MIO_ready(MIO_ready),
    .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .CPU_MIO(CPU_MIO), .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .Branch(Branch), .ALU_operation(ALU_operation),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [3:0]  exec_state;
    logic [2:0]  exec_alu;
    int          cycles;
  } vec_t;

  vec_t vecs[23];

  function automatic logic [24:0] all_outs();
    return {IorD, IRWrite, MemRead, MemWrite, CPU_MIO, RegDst, RegWrite, MemtoReg,
            ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, Branch,
            ALU_operation, state_out};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"add",   32'h00221820, 4'd6,  3'b010, 4};
    vecs[1]  = '{"sub",   32'h00221822, 4'd6,  3'b110, 4};
    vecs[2]  = '{"and",   32'h00221824, 4'd6,  3'b000, 4};
    vecs[3]  = '{"or",    32'h00221825, 4'd6,  3'b001, 4};
    vecs[4]  = '{"xor",   32'h00221826, 4'd6,  3'b011, 4};
    vecs[5]  = '{"nor",   32'h00221827, 4'd6,  3'b100, 4};
    vecs[6]  = '{"slt",   32'h0022182A, 4'd6,  3'b111, 4};
    vecs[7]  = '{"srl",   32'h00021842, 4'd6,  3'b101, 4};
    vecs[8]  = '{"jr",    32'h03E00008, 4'd14, 3'b000, 3};
    vecs[9]  = '{"lw",    32'h8C230004, 4'd2,  3'b010, 5};
    vecs[10] = '{"sw",    32'hAC230004, 4'd2,  3'b010, 4};
    vecs[11] = '{"beq",   32'h10220003, 4'd8,  3'b110, 3};
    vecs[12] = '{"bne",   32'h14220003, 4'd8,  3'b110, 3};
    vecs[13] = '{"addi",  32'h20220005, 4'd10, 3'b010, 4};
    vecs[14] = '{"andi",  32'h30220005, 4'd10, 3'b000, 4};
    vecs[15] = '{"ori",   32'h34220005, 4'd10, 3'b001, 4};
    vecs[16] = '{"xori",  32'h38220005, 4'd10, 3'b011, 4};
    vecs[17] = '{"slti",  32'h28220005, 4'd10, 3'b111, 4};
    vecs[18] = '{"lui",   32'h3C010005, 4'd12, 3'b000, 3};
    vecs[19] = '{"j",     32'h08000010, 4'd9,  3'b000, 3};
    vecs[20] = '{"jal",   32'h0C000010, 4'd13, 3'b000, 3};
    vecs[21] = '{"badop", 32'hFC000000, 4'd0,  3'b010, 2};
    vecs[22] = '{"badfn", 32'h0022183F, 4'd0,  3'b010, 2};

    reset = 1'b1; MIO_ready = 1'b1; Inst = 32'h0; zero = 1'b0;

    // Reset behaviour
    step();
    chk("reset_outs_1", 32'(all_outs()), 32'h0);
    step();
    chk("reset_outs_2", 32'(all_outs()), 32'h0);
    reset = 1'b0;
    #1;
    chk("if_state", 32'(state_out), 32'd0);
    chk("if_irwrite", 32'(IRWrite), 32'd1);
    chk("if_pcwrite", 32'(PCWrite), 32'd1);
    chk("if_alusrcb", 32'(ALUSrcB), 32'd1);
    chk("if_aluop", 32'(ALU_operation), 32'b010);
    chk("if_memread_mio", 32'({MemRead, CPU_MIO, IorD}), 32'b110);

    // IF stall
    MIO_ready = 1'b0;
    #1;
    chk("if_stall_strobes", 32'({IRWrite, PCWrite}), 32'b00);
    step();
    chk("if_stall_state", 32'(state_out), 32'd0);
    MIO_ready = 1'b1;

    // Table-driven dispatch and cycle counts
    foreach (vecs[i]) begin
      int n;
      Inst = vecs[i].inst;
      #1;
      chk({vecs[i].name, "_if"}, 32'(state_out), 32'd0);
      step();
      chk({vecs[i].name, "_id"}, 32'({state_out, ALUSrcB, ALU_operation}), {23'd0, 4'd1, 2'b11, 3'b010});
      step();
      chk({vecs[i].name, "_exec_state"}, 32'(state_out), 32'(vecs[i].exec_state));
      chk({vecs[i].name, "_exec_alu"}, 32'(ALU_operation), 32'(vecs[i].exec_alu));
      n = 2;
      while (state_out != 4'd0 && n < 12) begin
        step();
        n++;
      end
      chk({vecs[i].name, "_cycles"}, 32'(n), 32'(vecs[i].cycles));
    end

    // R-type write-back strobes
    Inst = 32'h00221820;
    step(); step(); step();
    chk("rwb_state", 32'(state_out), 32'd7);
    chk("rwb_strobes", 32'({RegWrite, RegDst, MemtoReg}), 32'b1_01_00);
    step();

    // lw with two MEM_RD stall cycles
    Inst = 32'h8C230004;
    step(); step(); step();
    chk("lw_memrd_state", 32'(state_out), 32'd3);
    chk("lw_memrd_strobes", 32'({IorD, MemRead, CPU_MIO}), 32'b111);
    MIO_ready = 1'b0;
    step();
    chk("lw_stall1", 32'({state_out, IorD}), {4'd3, 1'b1});
    step();
    chk("lw_stall2", 32'({state_out, IorD}), {4'd3, 1'b1});
    MIO_ready = 1'b1;
    step();
    chk("lw_memwb", 32'({state_out, RegWrite, RegDst, MemtoReg}), {4'd4, 1'b1, 2'b00, 2'b01});
    step();
    chk("lw_done", 32'(state_out), 32'd0);

    // sw with one MEM_WR stall
    Inst = 32'hAC230004;
    step(); step(); step();
    chk("sw_memwr", 32'({state_out, MemWrite, CPU_MIO, IorD, MemRead}), {4'd5, 4'b1110});
    MIO_ready = 1'b0;
    step();
    chk("sw_stall", 32'(state_out), 32'd5);
    MIO_ready = 1'b1;
    step();
    chk("sw_done", 32'(state_out), 32'd0);

    // beq / bne branch sense
    Inst = 32'h10220003;
    step(); step();
    chk("beq_outs", 32'({state_out, PCWriteCond, Branch, PCSource, ALUSrcA, ALUSrcB, PCWrite}),
        {4'd8, 1'b1, 1'b1, 2'b01, 1'b1, 2'b00, 1'b0});
    step();
    Inst = 32'h14220003;
    step(); step();
    chk("bne_outs", 32'({state_out, PCWriteCond, Branch}), {4'd8, 1'b1, 1'b0});
    step();

    // jal strobes
    Inst = 32'h0C000010;
    step(); step();
    chk("jal_outs", 32'({state_out, RegDst, MemtoReg, PCSource, PCWrite, RegWrite}),
        {4'd13, 2'b10, 2'b11, 2'b10, 1'b1, 1'b1});
    step();

    // jr and lui strobes
    Inst = 32'h03E00008;
    step(); step();
    chk("jr_outs", 32'({state_out, PCSource, PCWrite, RegWrite}), {4'd14, 2'b11, 1'b1, 1'b0});
    step();
    Inst = 32'h3C010005;
    step(); step();
    chk("lui_outs", 32'({state_out, RegWrite, MemtoReg, RegDst}), {4'd12, 1'b1, 2'b10, 2'b00});
    step();

    // Unsupported opcode: no write strobes anywhere
    Inst = 32'hFC000000;
    step();
    chk("badop_id_strobes", 32'({RegWrite, MemWrite, PCWriteCond, IRWrite, PCWrite}), 32'd0);
    step();
    chk("badop_back_if", 32'(state_out), 32'd0);

    // Reset in MEM_ADDR aborts the instruction
    Inst = 32'h8C230004;
    step(); step();
    chk("abort_memaddr", 32'({state_out, ALUSrcA, ALUSrcB}), {4'd2, 1'b1, 2'b10});
    reset = 1'b1;
    #1;
    chk("abort_reset_outs", 32'(all_outs()), 32'h0);
    step();
    reset = 1'b0;
    #1;
    chk("abort_state", 32'(state_out), 32'd0);
    chk("abort_if_irwrite", 32'(IRWrite), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
